// File: rtl/btu_pkg.sv
// Shared constants for the branch target unit: word width, mode encodings, link increment.
// Define BTU_MISALIGN_CHECK_EN to store and report a per-entry misalignment flag.
`ifndef WORD
`define WORD 32
`endif

package btu_pkg;
   localparam int BTU_WORD     = `WORD;
   localparam int BTU_LINK_INC = 4;

   typedef enum logic [1:0] {
      BTU_MODE_PCREL = 2'b00,
      BTU_MODE_REG   = 2'b01,
      BTU_MODE_ABS   = 2'b10,
      BTU_MODE_LINK  = 2'b11
   } btuMode_e;
endpackage

// File: rtl/btu_fifo.sv
// DEPTH-entry FIFO with non-power-of-two pointer wrap; push/pop ignored when full/empty.
module btu_fifo #(
   parameter int DEPTH = 2,
   parameter int DW    = 8,
   parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count;
   logic          doPush, doPop;

   assign full_o  = (count == CW'(DEPTH));
   assign empty_o = (count == '0);
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign data_o  = mem[rdPtr];

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= nextPtr(wrPtr);
         if (doPop)  rdPtr <= nextPtr(rdPtr);
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the top masks the head while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (doPush) mem[wrPtr] <= data_i;
   end
endmodule

// File: rtl/branch_target_unit.sv
// Control-transfer target/link calculator feeding a small handshaked result FIFO.
// Optional BTU_MISALIGN_CHECK_EN adds a stored per-entry misalignment flag.
module branch_target_unit
   import btu_pkg::*;
#(
   parameter int WIDTH        = BTU_WORD,
   parameter int OFFSET_SHIFT = 1,
   parameter int DEPTH        = 2,
   parameter int TAG_W        = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] pc_i,
   input  logic [WIDTH-1:0] base_i,
   input  logic [WIDTH-1:0] offset_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] target_o,
   output logic [WIDTH-1:0] link_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             misalign_o
);
   typedef struct packed {
      logic [WIDTH-1:0] target;
      logic [WIDTH-1:0] link;
      logic [TAG_W-1:0] tag;
`ifdef BTU_MISALIGN_CHECK_EN
      logic             misalign;
`endif
   } btuEntry_t;

   logic [WIDTH-1:0] addA, addB, sum, target, link;
   btuEntry_t        pushEntry, headEntry;
   logic             full, empty;

   // One shared adder; absolute mode adds zero, link mode adds the link increment.
   always_comb begin
      addA = pc_i;
      addB = WIDTH'(BTU_LINK_INC);
      case (btuMode_e'(mode_i))
         BTU_MODE_PCREL: begin addA = pc_i;   addB = offset_i << OFFSET_SHIFT; end
         BTU_MODE_REG:   begin addA = base_i; addB = offset_i; end
         BTU_MODE_ABS:   begin addA = '0;     addB = offset_i; end
         default:        ;
      endcase
   end

   assign sum    = addA + addB;
   assign target = (btuMode_e'(mode_i) == BTU_MODE_REG) ? {sum[WIDTH-1:1], 1'b0} : sum;
   assign link   = pc_i + WIDTH'(BTU_LINK_INC);

   always_comb begin
      pushEntry          = '0;
      pushEntry.target   = target;
      pushEntry.link     = link;
      pushEntry.tag      = tag_i;
`ifdef BTU_MISALIGN_CHECK_EN
      pushEntry.misalign = (target[1:0] != 2'b00);
`endif
   end

   btu_fifo #(
      .DEPTH (DEPTH),
      .DW    ($bits(btuEntry_t))
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (valid_i && ready_o),
      .pop_i   (ready_i && valid_o),
      .data_i  (pushEntry),
      .data_o  (headEntry),
      .full_o  (full),
      .empty_o (empty)
   );

   assign ready_o  = !full;
   assign valid_o  = !empty;
   assign target_o = valid_o ? headEntry.target : '0;
   assign link_o   = valid_o ? headEntry.link   : '0;
   assign tag_o    = valid_o ? headEntry.tag    : '0;
`ifdef BTU_MISALIGN_CHECK_EN
   assign misalign_o = valid_o && headEntry.misalign;
`else
   assign misalign_o = 1'b0;
`endif
endmodule
